// File: rtl/optic_flow_ci_pkg.sv
// rtl/optic_flow_ci_pkg.sv - shared opcodes and byte-lane offsets for the optic-flow custom instructions
package optic_flow_ci_pkg;

    typedef enum logic [1:0] {
        OP_COMPUTE = 2'd0,
        OP_SET_THR = 2'd1,
        OP_READ    = 2'd2,
        OP_CLEAR   = 2'd3
    } ci_opcode_e;

    localparam int LANE_LEFT  = 0;
    localparam int LANE_RIGHT = 8;
    localparam int LANE_UP    = 16;
    localparam int LANE_DOWN  = 24;

endpackage

// File: rtl/abs_diff_gt.sv
// rtl/abs_diff_gt.sv - combinational unsigned |a-b| > thr comparator
module abs_diff_gt #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] thr,
    output logic             gt
);

    logic [WIDTH-1:0] mag;

    // Subtract the smaller from the larger so the magnitude never wraps.
    always_comb begin
        mag = '0;
        if (a >= b) begin
            mag = a - b;
        end else begin
            mag = b - a;
        end
    end

    assign gt = (mag > thr);

endmodule

// File: rtl/grad_flag_acc_ci.sv
// rtl/grad_flag_acc_ci.sv - gradient flag custom instruction with saturating flag counters
module grad_flag_acc_ci
    import optic_flow_ci_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         PIXEL_WIDTH         = 8,
    parameter int         DEFAULT_THRESHOLD   = 10,
    parameter int         COUNT_WIDTH         = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  ciN,
    output logic        done,
    output logic [31:0] result
);

    localparam int P = PIXEL_WIDTH;
    localparam logic [P-1:0]           THR_RESET = DEFAULT_THRESHOLD[P-1:0];
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

    logic [P-1:0]           left;
    logic [P-1:0]           right;
    logic [P-1:0]           up;
    logic [P-1:0]           down;
    logic [P-1:0]           threshold;
    logic [COUNT_WIDTH-1:0] cnt_dx;
    logic [COUNT_WIDTH-1:0] cnt_dy;
    logic [15:0]            cnt_dx_ext;
    logic [15:0]            cnt_dy_ext;
    logic                   accept;
    logic                   flag_dx;
    logic                   flag_dy;
    logic                   unused_bits;
    ci_opcode_e             opcode;

    assign left   = valueA[LANE_LEFT  +: P];
    assign right  = valueA[LANE_RIGHT +: P];
    assign up     = valueA[LANE_UP    +: P];
    assign down   = valueA[LANE_DOWN  +: P];
    assign opcode = ci_opcode_e'(valueB[1:0]);
    assign accept = start && (ciN == customInstructionId);

    assign cnt_dx_ext  = 16'(cnt_dx);
    assign cnt_dy_ext  = 16'(cnt_dy);
    assign unused_bits = ^{valueB[31:2], valueA};

    abs_diff_gt #(.WIDTH(P)) u_diff_x (
        .a   (right),
        .b   (left),
        .thr (threshold),
        .gt  (flag_dx)
    );

    abs_diff_gt #(.WIDTH(P)) u_diff_y (
        .a   (up),
        .b   (down),
        .thr (threshold),
        .gt  (flag_dy)
    );

    // result defaults to zero every cycle so it is only non-zero alongside done.
    always_ff @(posedge clock) begin
        if (reset) begin
            done      <= 1'b0;
            result    <= 32'd0;
            threshold <= THR_RESET;
            cnt_dx    <= '0;
            cnt_dy    <= '0;
        end else begin
            done   <= accept;
            result <= 32'd0;
            if (accept) begin
                case (opcode)
                    OP_COMPUTE: begin
                        result <= {30'd0, flag_dy, flag_dx};
                        if (flag_dx && (cnt_dx != CNT_MAX)) begin
                            cnt_dx <= cnt_dx + CNT_ONE;
                        end
                        if (flag_dy && (cnt_dy != CNT_MAX)) begin
                            cnt_dy <= cnt_dy + CNT_ONE;
                        end
                    end
                    OP_SET_THR: begin
                        result    <= 32'(threshold);
                        threshold <= valueA[P-1:0];
                    end
                    OP_READ: begin
                        result <= {cnt_dy_ext, cnt_dx_ext};
                    end
                    OP_CLEAR: begin
                        cnt_dx <= '0;
                        cnt_dy <= '0;
                    end
                    default: begin
                        result <= 32'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_grad_flag_acc_ci.sv
// tb/tb_grad_flag_acc_ci.sv - randomized self-checking bench for grad_flag_acc_ci
module tb_grad_flag_acc_ci;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [7:0]  ciN;
    logic        done;
    logic [31:0] result;
    logic        done_sat;
    logic [31:0] result_sat;

    int errors = 0;
    int checks = 0;

    int m_thr;
    int m_dx;
    int m_dy;
    int m_dx2;
    int m_dy2;

    always #5 clock = ~clock;

    grad_flag_acc_ci dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .valueA (valueA),
        .valueB (valueB),
        .ciN    (ciN),
        .done   (done),
        .result (result)
    );

    grad_flag_acc_ci #(.COUNT_WIDTH(2)) dut_sat (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .valueA (valueA),
        .valueB (valueB),
        .ciN    (ciN),
        .done   (done_sat),
        .result (result_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_add(input int cnt, input int inc, input int max);
        return (cnt + inc > max) ? max : cnt + inc;
    endfunction

    task automatic model_reset();
        m_thr = 10;
        m_dx  = 0;
        m_dy  = 0;
        m_dx2 = 0;
        m_dy2 = 0;
    endtask

    task automatic op(input string tag, input logic rst, input logic st, input logic [7:0] ci,
                      input logic [1:0] opc, input logic [31:0] a);
        int          l, r, u, d, fx, fy;
        logic        exp_done;
        logic [31:0] exp_res;
        logic [31:0] exp_res_sat;
        reset  = rst;
        start  = st;
        ciN    = ci;
        valueA = a;
        valueB = {30'($urandom()), opc};
        exp_done    = 1'b0;
        exp_res     = 32'd0;
        exp_res_sat = 32'd0;
        if (rst) begin
            model_reset();
        end else if (st && ci == 8'd0) begin
            exp_done = 1'b1;
            case (opc)
                2'd0: begin
                    l  = int'(a[7:0]);
                    r  = int'(a[15:8]);
                    u  = int'(a[23:16]);
                    d  = int'(a[31:24]);
                    fx = (((r > l) ? r - l : l - r) > m_thr) ? 1 : 0;
                    fy = (((u > d) ? u - d : d - u) > m_thr) ? 1 : 0;
                    exp_res     = 32'(fy * 2 + fx);
                    exp_res_sat = exp_res;
                    m_dx  = sat_add(m_dx,  fx, 65535);
                    m_dy  = sat_add(m_dy,  fy, 65535);
                    m_dx2 = sat_add(m_dx2, fx, 3);
                    m_dy2 = sat_add(m_dy2, fy, 3);
                end
                2'd1: begin
                    exp_res     = 32'(m_thr);
                    exp_res_sat = exp_res;
                    m_thr       = int'(a[7:0]);
                end
                2'd2: begin
                    exp_res     = {16'(m_dy),  16'(m_dx)};
                    exp_res_sat = {16'(m_dy2), 16'(m_dx2)};
                end
                default: begin
                    m_dx  = 0;
                    m_dy  = 0;
                    m_dx2 = 0;
                    m_dy2 = 0;
                end
            endcase
        end
        @(posedge clock);
        #1;
        check({tag, ".done"},       32'(done),     32'(exp_done));
        check({tag, ".result"},     result,        exp_res);
        check({tag, ".done_sat"},   32'(done_sat), 32'(exp_done));
        check({tag, ".result_sat"}, result_sat,    exp_res_sat);
    endtask

    initial begin
        logic        rr;
        logic        ss;
        logic [7:0]  cc;
        logic [1:0]  oo;
        logic [31:0] aa;
        int          sel;

        model_reset();
        op("reset0", 1'b1, 1'b0, 8'd0, 2'd0, 32'd0);
        op("reset1", 1'b1, 1'b0, 8'd0, 2'd0, 32'd0);

        op("compute_first", 1'b0, 1'b1, 8'd0, 2'd0, 32'h0A00_0014);
        op("idle_after",    1'b0, 1'b0, 8'd0, 2'd0, 32'h0A00_0014);

        op("set_thr5",      1'b0, 1'b1, 8'd0, 2'd1, 32'd5);
        op("compute_thr5",  1'b0, 1'b1, 8'd0, 2'd0, 32'h0A00_0014);
        op("set_thr10",     1'b0, 1'b1, 8'd0, 2'd1, 32'd10);
        op("clear_a",       1'b0, 1'b1, 8'd0, 2'd3, 32'd0);

        for (int i = 0; i < 3; i++) op("compute_dx", 1'b0, 1'b1, 8'd0, 2'd0, 32'h0000_0014);
        op("compute_both",  1'b0, 1'b1, 8'd0, 2'd0, 32'h0014_0014);
        op("read_counts",   1'b0, 1'b1, 8'd0, 2'd2, 32'd0);

        op("clear_b",       1'b0, 1'b1, 8'd0, 2'd3, 32'd0);
        for (int i = 0; i < 5; i++) op("compute_sat", 1'b0, 1'b1, 8'd0, 2'd0, 32'h0000_1400);
        op("read_sat",      1'b0, 1'b1, 8'd0, 2'd2, 32'd0);
        op("clear_c",       1'b0, 1'b1, 8'd0, 2'd3, 32'd0);
        op("read_clear",    1'b0, 1'b1, 8'd0, 2'd2, 32'd0);

        op("compute_pre",   1'b0, 1'b1, 8'd0, 2'd0, 32'h0014_0014);
        for (int i = 0; i < 4; i++) op("foreign_ci", 1'b0, 1'b1, 8'h5A, 2'(i), 32'h0014_0014);
        op("read_foreign",  1'b0, 1'b1, 8'd0, 2'd2, 32'd0);
        op("thr_foreign",   1'b0, 1'b1, 8'd0, 2'd1, 32'd10);

        op("reset_accept",  1'b1, 1'b1, 8'd0, 2'd0, 32'h0014_0014);
        op("read_post_rst", 1'b0, 1'b1, 8'd0, 2'd2, 32'd0);
        op("thr_post_rst",  1'b0, 1'b1, 8'd0, 2'd1, 32'd10);

        for (int i = 0; i < 400; i++) begin
            rr  = ($urandom_range(0, 49) == 0);
            ss  = ($urandom_range(0, 3) != 0);
            cc  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            sel = $urandom_range(0, 9);
            oo  = (sel < 6) ? 2'd0 : (sel == 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            if (oo == 2'd1) begin
                aa = {24'($urandom()), 8'($urandom_range(0, 40))};
            end else if ($urandom_range(0, 4) == 0) begin
                aa = $urandom();
            end else begin
                aa = {8'($urandom_range(0, 60)), 8'($urandom_range(0, 60)),
                      8'($urandom_range(0, 60)), 8'($urandom_range(0, 60))};
            end
            op("random", rr, ss, cc, oo, aa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
